// File: rtl/pipeline_ctrl_pkg.sv
// Shared encodings for the pipeline stall/flush controller: stall vector layout,
// per-source stall patterns, register-address width and the timer state type.
package pipeline_ctrl_pkg;

    localparam int STALL_W    = 6;
    localparam int REG_ADDR_W = 5;
    localparam int MDU_CNT_W  = 4;

    // Bit positions inside the stall vector, PC first, WB hold last.
    localparam int STALL_PC     = 0;
    localparam int STALL_IF_ID  = 1;
    localparam int STALL_ID_EX  = 2;
    localparam int STALL_EX_MEM = 3;
    localparam int STALL_MEM_WB = 4;
    localparam int STALL_WB     = 5;

    typedef logic [STALL_W-1:0]    stall_vec_t;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    localparam stall_vec_t STALL_NONE = 6'b000000;
    localparam stall_vec_t STALL_IF   = 6'b000011;
    localparam stall_vec_t STALL_ID   = 6'b000111;
    localparam stall_vec_t STALL_EX   = 6'b001111;
    localparam stall_vec_t STALL_MEM  = 6'b011111;

    localparam reg_addr_t ZERO_REG_ADDR = '0;

    typedef enum logic {
        IDLE     = 1'b0,
        MDU_BUSY = 1'b1
    } mdu_state_t;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Stall/flush bundle between the pipeline stages (master) and the controller (slave).
interface pipeline_ctrl_if
    import pipeline_ctrl_pkg::*;
#(
    parameter int CNT_WIDTH = 32
);
    logic                 if_stall_request;
    logic                 id_stall_request;
    logic                 mem_stall_request;
    logic                 id_reg_read_en_1;
    logic                 id_reg_read_en_2;
    reg_addr_t            id_reg_addr_1;
    reg_addr_t            id_reg_addr_2;
    logic                 ex_mem_read;
    reg_addr_t            ex_write_reg_addr;
    logic                 ex_mdu_start;
    logic                 exception;
    stall_vec_t           stall;
    logic                 flush;
    logic                 mdu_done;
    logic                 mdu_busy;
    logic [CNT_WIDTH-1:0] stall_cycles;

    modport master (
        output if_stall_request, id_stall_request, mem_stall_request,
        output id_reg_read_en_1, id_reg_read_en_2, id_reg_addr_1, id_reg_addr_2,
        output ex_mem_read, ex_write_reg_addr, ex_mdu_start, exception,
        input  stall, flush, mdu_done, mdu_busy, stall_cycles
    );

    modport slave (
        input  if_stall_request, id_stall_request, mem_stall_request,
        input  id_reg_read_en_1, id_reg_read_en_2, id_reg_addr_1, id_reg_addr_2,
        input  ex_mem_read, ex_write_reg_addr, ex_mdu_start, exception,
        output stall, flush, mdu_done, mdu_busy, stall_cycles
    );
endinterface

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use hazard detect: load in EX writes a register that ID is reading this cycle.
// Latency: combinational, same cycle.
// Backpressure: none; the hazard drops by itself once the load leaves EX.
module pipeline_ctrl_hazard_detect
    import pipeline_ctrl_pkg::*;
(
    input  logic      ex_mem_read,
    input  reg_addr_t ex_write_reg_addr,
    input  logic      id_reg_read_en_1,
    input  reg_addr_t id_reg_addr_1,
    input  logic      id_reg_read_en_2,
    input  reg_addr_t id_reg_addr_2,
    output logic      load_use
);

    logic src1_hit;
    logic src2_hit;

    assign src1_hit = id_reg_read_en_1 && (id_reg_addr_1 == ex_write_reg_addr);
    assign src2_hit = id_reg_read_en_2 && (id_reg_addr_2 == ex_write_reg_addr);

    // x0 is hard-wired, so a load targeting it never creates a dependency.
    assign load_use = ex_mem_read && (ex_write_reg_addr != ZERO_REG_ADDR)
                      && (src1_hit || src2_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush controller: prioritises stage stall requests, times multi-cycle EX ops.
// Latency: stall/flush/mdu_done combinational from inputs and current state, same cycle.
// Backpressure: a MEM stall freezes the MDU timer; exceptions flush and abort any op.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int MDU_LATENCY = 4,
    parameter int CNT_WIDTH   = 32
)(
    input  logic                 clk,
    input  logic                 rst,
    pipeline_ctrl_if.slave       bus
);

    localparam logic [MDU_CNT_W-1:0] CNT_LOAD = MDU_CNT_W'(MDU_LATENCY - 1);
    localparam logic [MDU_CNT_W-1:0] CNT_LAST = MDU_CNT_W'(1);

    mdu_state_t           state;
    mdu_state_t           state_nxt;
    logic [MDU_CNT_W-1:0] cnt;
    logic [MDU_CNT_W-1:0] cnt_nxt;
    logic [CNT_WIDTH-1:0] stall_cnt;

    logic       load_use;
    logic       ex_src;
    logic       id_src;
    stall_vec_t stall_sel;
    logic       flush_sel;

    pipeline_ctrl_hazard_detect u_hazard_detect (
        .ex_mem_read       (bus.ex_mem_read),
        .ex_write_reg_addr (bus.ex_write_reg_addr),
        .id_reg_read_en_1  (bus.id_reg_read_en_1),
        .id_reg_addr_1     (bus.id_reg_addr_1),
        .id_reg_read_en_2  (bus.id_reg_read_en_2),
        .id_reg_addr_2     (bus.id_reg_addr_2),
        .load_use          (load_use)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (bus.exception) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    // An op cannot begin while MEM holds EX; it starts once MEM releases.
                    if (bus.ex_mdu_start && !bus.mem_stall_request) begin
                        state_nxt = MDU_BUSY;
                        cnt_nxt   = CNT_LOAD;
                    end
                end
                MDU_BUSY: begin
                    if (!bus.mem_stall_request) begin
                        if (cnt == CNT_LAST) begin
                            state_nxt = IDLE;
                            cnt_nxt   = '0;
                        end else begin
                            cnt_nxt = cnt - 1'b1;
                        end
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_comb begin
        ex_src    = ((state == IDLE) && bus.ex_mdu_start) || (state == MDU_BUSY);
        id_src    = load_use || bus.id_stall_request;
        stall_sel = STALL_NONE;
        flush_sel = 1'b0;
        if (bus.exception) begin
            flush_sel = 1'b1;
        end else if (bus.mem_stall_request) begin
            stall_sel = STALL_MEM;
        end else if (ex_src) begin
            stall_sel = STALL_EX;
        end else if (id_src) begin
            stall_sel = STALL_ID;
        end else if (bus.if_stall_request) begin
            stall_sel = STALL_IF;
        end

        // Outputs stay quiet while reset is held, whatever the request inputs do.
        bus.stall    = rst ? stall_sel : STALL_NONE;
        bus.flush    = rst && flush_sel;
        bus.mdu_done = rst && (state == MDU_BUSY) && (cnt == CNT_LAST)
                       && !bus.mem_stall_request && !bus.exception;
        bus.mdu_busy = (state == MDU_BUSY);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (bus.stall[STALL_PC] && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign bus.stall_cycles = stall_cnt;

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush controller for the five-stage core. Collects stall requests from IF, ID, EX and MEM, detects load-use hazards from ID's register-read requests, and sequences multi-cycle EX operations (mul/div) with an internal timer. Produces the per-stage stall vector consumed by PC and the pipeline registers, a flush for exceptions, and a saturating stall-cycle counter.

## Interface
- MDU_LATENCY, 4, cycles a multi-cycle EX op occupies EX (legal range 2..15)
- CNT_WIDTH, 32, width of the stall performance counter

- clk  input  1  core clock, all state on rising edge
- rst  input  1  asynchronous, active-low reset
- if_stall_request  input  1  IF requests stall (instruction fetch not ready)
- id_stall_request  input  1  ID requests stall
- mem_stall_request  input  1  MEM requests stall (data access not ready)
- id_reg_read_en_1 / id_reg_read_en_2  input  1 each  ID source read enables
- id_reg_addr_1 / id_reg_addr_2  input  5 each  ID source register addresses
- ex_mem_read  input  1  instruction in EX is a load
- ex_write_reg_addr  input  5  destination of instruction in EX
- ex_mdu_start  input  1  instruction in EX is a multi-cycle op, first EX cycle
- exception  input  1  MEM-stage exception, flush request
- stall  output  6  [0]=PC, [1]=IF/ID, [2]=ID/EX, [3]=EX/MEM, [4]=MEM/WB, [5]=WB hold
- flush  output  1  clear all pipeline registers this cycle
- mdu_done  output  1  last cycle of a multi-cycle op; EX result valid
- mdu_busy  output  1  timer active
- stall_cycles  output  CNT_WIDTH  count of cycles with stall[0]=1, saturating

## Operation
- States: IDLE, MDU_BUSY. Down-counter cnt, width 4.
- Stall source priority (highest first): exception, mem_stall_request, EX (mdu), ID (load-use or id_stall_request), if_stall_request.
- Stall vector per winning source: exception 000000 with flush=1; MEM 011111; EX 001111; ID 000111; IF 000011; none 000000. Stage k's output register receives a bubble (handled by pipeline regs: stall[k]=1, stall[k+1]=0).
- Load-use hazard: ex_mem_read & ex_write_reg_addr!=0 & ((id_reg_read_en_1 & id_reg_addr_1==ex_write_reg_addr) | (id_reg_read_en_2 & id_reg_addr_2==ex_write_reg_addr)). Purely combinational; clears naturally when the load advances.
- EX stall source = (IDLE & ex_mdu_start) | MDU_BUSY.
- IDLE & ex_mdu_start & no higher-priority source: next state MDU_BUSY, cnt <= MDU_LATENCY-1.
- MDU_BUSY: if MEM stall is active cnt holds; else cnt decrements. cnt==1 and no MEM stall: mdu_done=1, next state IDLE.
- ex_mdu_start while MDU_BUSY ignored.
- exception in any state: flush=1, stall=000000, state <= IDLE, cnt <= 0, mdu_done=0.
- stall_cycles increments every cycle stall[0]=1, saturates at all-ones; not cleared by flush.

## Timing
- Reset (rst=0, async): state IDLE, cnt 0, stall_cycles 0. Outputs during reset: stall 000000, flush 0, mdu_done 0, mdu_busy 0.
- stall, flush, mdu_done combinational from inputs and current state, same cycle; no added latency.
- Uninterrupted multi-cycle op starting cycle T: stall=001111 in cycles T..T+MDU_LATENCY-1, mdu_busy 1 in T+1..T+MDU_LATENCY-1, mdu_done 1 only in T+MDU_LATENCY-1; pipeline advances at T+MDU_LATENCY.
- MEM stall during MDU_BUSY extends the op one cycle per MEM-stall cycle; stall shows 011111 for those cycles.
- Exception in cycle of mdu_done: flush wins, mdu_done=0.
- Reset release mid-operation: resumes from IDLE; no partial op continues.
- Counter saturation: at all-ones, stays all-ones.

## Structure
- Shared package/defines: stall vector width and the five stall encodings, stall bit indices, REG_ADDR width, ZERO_REG_ADDR.
- One sub-module: hazard_detect (combinational load-use compare). Timer FSM, priority mux and counter stay in pipeline_ctrl.

## Test plan
- Reset asserted mid-MDU (cnt=2), released -> stall 000000, mdu_busy 0, stall_cycles 0.
- ex_mem_read=1, ex_write_reg_addr=8, id_reg_read_en_2=1, id_reg_addr_2=8 -> stall 000111 one cycle; same with address 0 -> stall 000000.
- MDU_LATENCY=4, ex_mdu_start at T -> stall 001111 for T..T+3, mdu_done only at T+3, stall_cycles +4.
- Same op with mem_stall_request at T+2 -> stall 011111 at T+2, mdu_done moves to T+4.
- exception at T+1 of an MDU op plus if_stall_request -> flush=1, stall 000000, next cycle IDLE, no mdu_done.
- if_stall_request and id load-use simultaneous -> stall 000111; IF alone -> 000011.
